// File: rtl/pfd_lf_pkg.sv
// Shared types, default widths and saturating arithmetic helpers for the
// pfd loop filter.
package pfd_lf_pkg;

    localparam int unsigned CTRL_W_DEF    = 8;
    localparam int unsigned ERR_W_DEF     = 8;
    localparam int unsigned KP_SHIFT_DEF  = 1;
    localparam int unsigned KI_FRAC_DEF   = 2;
    localparam int unsigned INIT_CODE_DEF = 128;
    localparam int unsigned LOCK_TOL_DEF  = 1;
    localparam int unsigned LOCK_CNT_DEF  = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MEAS = 2'd1,
        ST_UPD  = 2'd2
    } lf_state_e;

    // Clamp a signed value into [lo, hi]. Helpers work at 32 bits, so all
    // intermediate widths of the filter must stay below 32 bits.
    function automatic logic signed [31:0] clamp_s(input logic signed [31:0] v,
                                                   input logic signed [31:0] lo,
                                                   input logic signed [31:0] hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    // a + b, saturated symmetrically to +/-(2^(w-1)-1).
    function automatic logic signed [31:0] sat_add_sym(input logic signed [31:0] a,
                                                       input logic signed [31:0] b,
                                                       input int unsigned       w);
        logic signed [31:0] lim;
        lim = (32'sd1 <<< (w - 1)) - 32'sd1;
        return clamp_s(a + b, -lim, lim);
    endfunction

endpackage

// File: rtl/pfd_lf_sync.sv
// Two-flop synchronizer for one asynchronous pfd pulse line.
module pfd_lf_sync
    import pfd_lf_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Double-register the asynchronous input into the clk_i domain.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pfd_loop_filter.sv
// Digital PI loop filter fed by pfd UP/DOWN pulses. Each pulse is measured
// as a signed cycle count, then applied to a clamped integrator and a
// proportional path to produce a saturated DCO control code.
// Optional lock detector: define PFD_LF_LOCK_EN (otherwise LOCK is tied 0).
module pfd_loop_filter
    import pfd_lf_pkg::*;
#(
    parameter int unsigned CTRL_W    = CTRL_W_DEF,
    parameter int unsigned ERR_W     = ERR_W_DEF,
    parameter int unsigned KP_SHIFT  = KP_SHIFT_DEF,
    parameter int unsigned KI_FRAC   = KI_FRAC_DEF,
    parameter int unsigned INIT_CODE = INIT_CODE_DEF,
    parameter int unsigned LOCK_TOL  = LOCK_TOL_DEF,
    parameter int unsigned LOCK_CNT  = LOCK_CNT_DEF
)
(
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic              UP,
    input  logic              DOWN,
    output logic [CTRL_W-1:0] CTRL,
    output logic              UPD,
    output logic              SAT_HI,
    output logic              SAT_LO,
    output logic              LOCK,
    inout  wire               VDD,
    inout  wire               VSS
);

    localparam int unsigned INT_W    = CTRL_W + KI_FRAC;
    localparam int unsigned SUM_W    = CTRL_W + ERR_W + 2;
    localparam int          CTRL_MAX = (1 << CTRL_W) - 1;
    localparam int          INT_MAX  = CTRL_MAX << KI_FRAC;

    lf_state_e               state_q, state_d;
    logic signed [ERR_W-1:0] err_q, err_d;
    logic [INT_W-1:0]        int_q, int_d;
    logic [CTRL_W-1:0]       ctrl_q, ctrl_d;
    logic                    upd_q, upd_d;
    logic                    sat_hi_q, sat_hi_d;
    logic                    sat_lo_q, sat_lo_d;

    logic                    us, ds;
    logic signed [1:0]       step;
    logic signed [31:0]      int_new;
    logic signed [SUM_W-1:0] sum;

    logic                    unused_supply;
    assign unused_supply = VDD ^ VSS;

    pfd_lf_sync u_sync_up (
        .clk_i (CLK),
        .rst_i (RST),
        .d_i   (UP),
        .q_o   (us)
    );

    pfd_lf_sync u_sync_dn (
        .clk_i (CLK),
        .rst_i (RST),
        .d_i   (DOWN),
        .q_o   (ds)
    );

    // Per-cycle phase step: exclusive UP counts +1, exclusive DOWN -1.
    always_comb begin
        step = 2'sd0;
        if (us && !ds) begin
            step = 2'sd1;
        end else if (ds && !us) begin
            step = -2'sd1;
        end
    end

    // Candidate PI result from the current err; committed only in ST_UPD.
    always_comb begin
        int_new = clamp_s(signed'(32'(int_q)) + 32'(err_q), 32'sd0, INT_MAX);
        sum     = SUM_W'(int_new >>> KI_FRAC) + (SUM_W'(err_q) <<< KP_SHIFT);
    end

    // Pulse measurement FSM and filter update.
    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        int_d    = int_q;
        ctrl_d   = ctrl_q;
        upd_d    = 1'b0;
        sat_hi_d = sat_hi_q;
        sat_lo_d = sat_lo_q;
        unique case (state_q)
            ST_IDLE: begin
                if (EN && (us || ds)) begin
                    state_d = ST_MEAS;
                    err_d   = ERR_W'(step);
                end
            end
            ST_MEAS: begin
                if (!EN) begin
                    state_d = ST_IDLE;
                    err_d   = '0;
                end else if (!us && !ds) begin
                    state_d = ST_UPD;
                end else begin
                    err_d = ERR_W'(sat_add_sym(32'(err_q), 32'(step), ERR_W));
                end
            end
            ST_UPD: begin
                int_d    = INT_W'(int_new);
                ctrl_d   = CTRL_W'(clamp_s(32'(sum), 32'sd0, CTRL_MAX));
                sat_hi_d = (32'(sum) > CTRL_MAX);
                sat_lo_d = sum[SUM_W-1];
                upd_d    = 1'b1;
                err_d    = '0;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                err_d   = '0;
            end
        endcase
    end

    // State, accumulator and registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            err_q    <= '0;
            int_q    <= INT_W'(INIT_CODE) << KI_FRAC;
            ctrl_q   <= CTRL_W'(INIT_CODE);
            upd_q    <= 1'b0;
            sat_hi_q <= 1'b0;
            sat_lo_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            err_q    <= err_d;
            int_q    <= int_d;
            ctrl_q   <= ctrl_d;
            upd_q    <= upd_d;
            sat_hi_q <= sat_hi_d;
            sat_lo_q <= sat_lo_d;
        end
    end

    assign CTRL   = ctrl_q;
    assign UPD    = upd_q;
    assign SAT_HI = sat_hi_q;
    assign SAT_LO = sat_lo_q;

`ifdef PFD_LF_LOCK_EN
    localparam int unsigned LCW = $clog2(LOCK_CNT + 1);

    logic [LCW-1:0]   lcnt_q, lcnt_d;
    logic             lock_q, lock_d;
    logic [ERR_W-1:0] err_mag;

    // Count consecutive small-error updates; LOCK rises with the update
    // that brings the count to LOCK_CNT.
    always_comb begin
        err_mag = err_q[ERR_W-1] ? ERR_W'(-err_q) : ERR_W'(err_q);
        lcnt_d  = lcnt_q;
        lock_d  = lock_q;
        if (!EN) begin
            lcnt_d = '0;
            lock_d = 1'b0;
        end else if (state_q == ST_UPD) begin
            if (err_mag <= ERR_W'(LOCK_TOL)) begin
                if (lcnt_q < LCW'(LOCK_CNT)) begin
                    lcnt_d = lcnt_q + LCW'(1);
                end
                lock_d = (lcnt_d == LCW'(LOCK_CNT));
            end else begin
                lcnt_d = '0;
                lock_d = 1'b0;
            end
        end
    end

    // Lock counter and indicator registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lcnt_q <= '0;
            lock_q <= 1'b0;
        end else begin
            lcnt_q <= lcnt_d;
            lock_q <= lock_d;
        end
    end

    assign LOCK = lock_q;
`else
    localparam int unsigned unused_lock_cfg = LOCK_TOL + LOCK_CNT;
    assign LOCK = 1'b0;
`endif

endmodule

// File: tb/tb_pfd_loop_filter.sv
// Self-checking bench for pfd_loop_filter: directed cases followed by
// randomized pulse trains, compared against an arithmetic reference model.
module tb_pfd_loop_filter;

    localparam int CTRL_W    = 8;
    localparam int ERR_W     = 8;
    localparam int KP_SHIFT  = 1;
    localparam int KI_FRAC   = 2;
    localparam int INIT_CODE = 128;
    localparam int LOCK_TOL  = 1;
    localparam int LOCK_CNT  = 4;
    localparam int ERR_LIM   = (1 << (ERR_W - 1)) - 1;
    localparam int CTRL_MAX  = (1 << CTRL_W) - 1;
    localparam int INT_MAX   = CTRL_MAX * (1 << KI_FRAC);

    logic              clk = 1'b0;
    logic              rst, en, up, down;
    logic [CTRL_W-1:0] ctrl;
    logic              upd, sat_hi, sat_lo, lock;
    wire               vdd = 1'b1;
    wire               vss = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    int m_int, m_ctrl, m_lcnt;
    bit m_sat_hi, m_sat_lo, m_lock;

    logic [1:0] pat[$];   // bit1 = UP, bit0 = DOWN, one entry per clock

    pfd_loop_filter #(
        .CTRL_W    (CTRL_W),
        .ERR_W     (ERR_W),
        .KP_SHIFT  (KP_SHIFT),
        .KI_FRAC   (KI_FRAC),
        .INIT_CODE (INIT_CODE),
        .LOCK_TOL  (LOCK_TOL),
        .LOCK_CNT  (LOCK_CNT)
    ) dut (
        .CLK    (clk),
        .RST    (rst),
        .EN     (en),
        .UP     (up),
        .DOWN   (down),
        .CTRL   (ctrl),
        .UPD    (upd),
        .SAT_HI (sat_hi),
        .SAT_LO (sat_lo),
        .LOCK   (lock),
        .VDD    (vdd),
        .VSS    (vss)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_int    = INIT_CODE * (1 << KI_FRAC);
        m_ctrl   = INIT_CODE;
        m_sat_hi = 1'b0;
        m_sat_lo = 1'b0;
        m_lcnt   = 0;
        m_lock   = 1'b0;
    endtask

    task automatic model_update(input int err);
        int sum;
        m_int = m_int + err;
        if (m_int < 0)       m_int = 0;
        if (m_int > INT_MAX) m_int = INT_MAX;
        sum      = m_int / (1 << KI_FRAC) + err * (1 << KP_SHIFT);
        m_sat_hi = (sum > CTRL_MAX);
        m_sat_lo = (sum < 0);
        m_ctrl   = m_sat_hi ? CTRL_MAX : (m_sat_lo ? 0 : sum);
`ifdef PFD_LF_LOCK_EN
        if (err <= LOCK_TOL && err >= -LOCK_TOL) begin
            if (m_lcnt < LOCK_CNT) m_lcnt++;
        end else begin
            m_lcnt = 0;
        end
        m_lock = (m_lcnt == LOCK_CNT);
`endif
    endtask

    function automatic int pat_err();
        int e = 0;
        foreach (pat[i]) begin
            if (pat[i] == 2'b10)      e++;
            else if (pat[i] == 2'b01) e--;
            if (e > ERR_LIM)  e = ERR_LIM;
            if (e < -ERR_LIM) e = -ERR_LIM;
        end
        return e;
    endfunction

    task automatic fill(input logic [1:0] v, input int n);
        repeat (n) pat.push_back(v);
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".ctrl"},   ctrl,   m_ctrl);
        check({tag, ".sat_hi"}, sat_hi, m_sat_hi);
        check({tag, ".sat_lo"}, sat_lo, m_sat_lo);
        check({tag, ".lock"},   lock,   m_lock);
    endtask

    // Drive pat, then idle; UPD must appear on the 4th edge after the
    // first idle drive (2 sync stages + measurement exit + update).
    task automatic run_pulse(input string tag);
        int err;
        int seen;
        err = pat_err();
        foreach (pat[i]) begin
            up   = pat[i][1];
            down = pat[i][0];
            @(posedge clk); #1;
        end
        up   = 1'b0;
        down = 1'b0;
        seen = -1;
        for (int i = 0; i < 8 && seen < 0; i++) begin
            @(posedge clk); #1;
            if (upd === 1'b1) seen = i;
        end
        check({tag, ".latency"}, seen, 3);
        model_update(err);
        check_outputs(tag);
        @(posedge clk); #1;
        check({tag, ".upd_width"}, upd, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        pat.delete();
    endtask

    task automatic apply_reset();
        @(posedge clk); #1;
        rst  = 1'b1;
        up   = 1'b0;
        down = 1'b0;
        #2;
        model_reset();
        check_outputs("rst");
        check("rst.upd", upd, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic rand_pulse(input int bias, input string tag);
        int len;
        int r;
        pat.delete();
        len = ($urandom_range(0, 5) == 0) ? $urandom_range(100, 160) : $urandom_range(1, 12);
        for (int i = 0; i < len; i++) begin
            r = $urandom_range(0, 9);
            case (bias)
                0:       pat.push_back(r < 7 ? 2'b01 : (r < 9 ? 2'b11 : 2'b10));
                1:       pat.push_back(r < 7 ? 2'b10 : (r < 9 ? 2'b11 : 2'b01));
                default: pat.push_back(r < 4 ? 2'b10 : (r < 8 ? 2'b01 : 2'b11));
            endcase
        end
        run_pulse(tag);
    endtask

    initial begin
        int upd_seen;
        rst  = 1'b1;
        en   = 1'b1;
        up   = 1'b0;
        down = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_outputs("por");
        check("por.upd", upd, 1'b0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // UP for 6 sampled cycles
        fill(2'b10, 6);
        run_pulse("up6");
        check("up6.code", ctrl, 141);

        // DOWN for 6 cycles from reset
        apply_reset();
        fill(2'b01, 6);
        run_pulse("dn6");
        check("dn6.code", ctrl, 114);

        // Over-range UP pulse saturates err and clamps CTRL high
        apply_reset();
        fill(2'b10, 200);
        run_pulse("up200");
        check("up200.code", ctrl, 255);
        check("up200.sathi", sat_hi, 1'b1);
        fill(2'b01, 6);
        run_pulse("dn6_after_sat");
        check("dn6_after_sat.code", ctrl, 146);
        check("dn6_after_sat.sathi", sat_hi, 1'b0);

        // Overlap-only pulse: err=0 update from INT
        apply_reset();
        fill(2'b11, 3);
        run_pulse("overlap");
        check("overlap.code", ctrl, 128);

        // Reset in the middle of a pulse
        apply_reset();
        fill(2'b10, 6);
        run_pulse("pre_rst");
        up = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        model_reset();
        check_outputs("rst_mid");
        check("rst_mid.upd", upd, 1'b0);
        up = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        fill(2'b01, 6);
        run_pulse("post_rst");

        // Lock sequence err = +1, -1, 0, +1, then +3
        apply_reset();
        fill(2'b10, 1); run_pulse("lk1");
        fill(2'b01, 1); run_pulse("lk2");
        fill(2'b11, 1); run_pulse("lk3");
        fill(2'b10, 1); run_pulse("lk4");
`ifdef PFD_LF_LOCK_EN
        check("lk4.locked", lock, 1'b1);
`endif
        fill(2'b10, 3); run_pulse("lk_break");
        check("lk_break.unlocked", lock, 1'b0);
        fill(2'b01, 1); run_pulse("lk5");
        fill(2'b10, 1); run_pulse("lk6");
        fill(2'b11, 2); run_pulse("lk7");
        fill(2'b01, 1); run_pulse("lk8");

        // EN dropped mid-pulse: no update, state held, lock cleared
        up = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        en = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        up = 1'b0;
        upd_seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (upd === 1'b1) upd_seen++;
        end
        check("en_off.no_upd", upd_seen, 0);
`ifdef PFD_LF_LOCK_EN
        m_lcnt = 0;
        m_lock = 1'b0;
`endif
        check_outputs("en_off");
        en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        fill(2'b10, 6);
        run_pulse("en_back");

        // Randomized pulse trains: down-biased, up-biased, mixed
        for (int k = 0; k < 12; k++) rand_pulse(0, $sformatf("rnd_dn%0d", k));
        for (int k = 0; k < 14; k++) rand_pulse(1, $sformatf("rnd_up%0d", k));
        for (int k = 0; k < 20; k++) rand_pulse(2, $sformatf("rnd_mx%0d", k));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
